// File: rtl/vx_tensor_pair_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vx_tensor_pair_arbiter                                       |
// | Description : Round-robin issue arbiter for HMMA micro-op pairs. Locks the |
// |               tensor dispatch port to one warp from its first half until   |
// |               its second half fires, and limits in-flight pairs with a     |
// |               credit counter that commit completions replenish.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vx_tensor_pair_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int CREDITS  = 2,
  localparam int IDXW    = $clog2(NUM_REQS),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0]            req_last,
  input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [DATAW-1:0]               out_data,
  output logic [IDXW-1:0]                out_idx,
  input  logic                           out_ready,
  input  logic                           done,
  output logic                           locked,
  output logic [IDXW-1:0]                lock_idx,
  output logic [CW-1:0]                  credits,
  output logic                           proto_err
);

  localparam logic [CW-1:0]   C_CREDITS_MAX = CW'(CREDITS);
  localparam logic [IDXW-1:0] C_LAST_IDX    = IDXW'(NUM_REQS - 1);
  localparam logic [IDXW:0]   C_NUM_REQS_W  = (IDXW + 1)'(NUM_REQS);

  logic                locked_q,    locked_d;
  logic [IDXW-1:0]     lock_idx_q,  lock_idx_d;
  logic [IDXW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]       credits_q,   credits_d;
  logic                proto_err_q, proto_err_d;

  logic                w_has_credit;
  logic [NUM_REQS-1:0] w_eligible;
  logic [NUM_REQS-1:0] w_owner_mask;
  logic                w_grant_any;
  logic [IDXW-1:0]     w_grant_idx;
  logic                w_fire;
  logic                w_first_fire;
  logic                w_second_fire;
  logic                w_done_ok;
  logic                w_overflow;
  logic                w_last_nonowner;
  logic                w_owner_first;

  assign w_has_credit = (credits_q != '0);

  // Per-requester eligibility and ownership; while a pair is open only the
  // owner's second half may pass, otherwise any first half with a credit.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_elig
    assign w_owner_mask[i] = locked_q && (lock_idx_q == IDXW'(i));
    assign w_eligible[i]   = locked_q ? (w_owner_mask[i] && req_valid[i] && req_last[i])
                                      : (req_valid[i] && !req_last[i] && w_has_credit);
    assign req_ready[i]    = w_grant_any && (w_grant_idx == IDXW'(i)) && out_ready;
  end

  // Round-robin scan starting at rr_ptr; when locked only the owner can be
  // eligible, so the same scan yields lock_idx.
  always_comb begin
    logic [IDXW:0] pos;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    pos         = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      pos = {1'b0, rr_ptr_q} + (IDXW + 1)'(k);
      if (pos >= C_NUM_REQS_W) begin
        pos = pos - C_NUM_REQS_W;
      end
      if (!w_grant_any && w_eligible[pos[IDXW-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = pos[IDXW-1:0];
      end
    end
  end

  assign out_valid = w_grant_any;
  assign out_idx   = w_grant_any ? w_grant_idx : '0;
  assign out_last  = w_grant_any ? req_last[w_grant_idx] : 1'b0;
  assign out_data  = w_grant_any ? req_data[w_grant_idx] : '0;

  assign w_fire        = w_grant_any && out_ready;
  assign w_first_fire  = w_fire && !out_last;
  assign w_second_fire = w_fire && out_last;

  // A done at full credits has nothing to return: it is dropped and flagged.
  assign w_overflow = done && (credits_q == C_CREDITS_MAX);
  assign w_done_ok  = done && !w_overflow;

  assign w_last_nonowner = |(req_valid & req_last & ~w_owner_mask);
  assign w_owner_first   = locked_q && req_valid[lock_idx_q] && !req_last[lock_idx_q];

  // Next-state for lock ownership, round-robin pointer, credits and error flag.
  always_comb begin
    locked_d    = locked_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    credits_d   = credits_q;
    proto_err_d = proto_err_q;

    if (w_first_fire) begin
      locked_d   = 1'b1;
      lock_idx_d = w_grant_idx;
    end else if (w_second_fire) begin
      locked_d   = 1'b0;
      lock_idx_d = '0;
      rr_ptr_d   = (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
    end

    // First-half fire only happens with credits > 0, so no underflow here.
    if (w_done_ok && !w_first_fire) begin
      credits_d = credits_q + 1'b1;
    end else if (!w_done_ok && w_first_fire) begin
      credits_d = credits_q - 1'b1;
    end

    if (w_last_nonowner || w_owner_first || w_overflow) begin
      proto_err_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset drops any open pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q    <= 1'b0;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      credits_q   <= C_CREDITS_MAX;
      proto_err_q <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign locked    = locked_q;
  assign lock_idx  = lock_idx_q;
  assign credits   = credits_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_tensor_pair_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vx_tensor_pair_arbiter                                    |
// | Description : Directed scoreboard bench for vx_tensor_pair_arbiter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vx_tensor_pair_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_idx;
  logic              out_ready;
  logic              done;
  logic              locked;
  logic [1:0]        lock_idx;
  logic [1:0]        credits;
  logic              proto_err;

  typedef struct packed {
    logic [1:0]    idx;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  vx_tensor_pair_arbiter #(.NUM_REQS(N), .DATAW(DW), .CREDITS(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_idx(out_idx), .out_ready(out_ready),
    .done(done), .locked(locked), .lock_idx(lock_idx),
    .credits(credits), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(int w, int l, int t);
    return {8'hA5, 8'(w), 8'(l), 40'(t)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic set_req(int w, logic v, logic l, int t);
    req_valid[w] = v;
    req_last[w]  = l;
    req_data[w]  = v ? dat(w, int'(l), t) : '0;
  endtask

  task automatic push(int w, logic l, int t);
    exp_t e;
    e.idx  = 2'(w);
    e.last = l;
    e.data = dat(w, int'(l), t);
    exp_q.push_back(e);
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every fire pops one expected uop; also checks lock consistency.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (locked) begin
        n_cmp++;
        if (out_idx !== lock_idx) begin
          n_bad++;
          $display("FAIL lock_owner: out_idx %0d lock_idx %0d", out_idx, lock_idx);
        end
      end
      if (out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_fire: idx %0d last %0b data %0h, none expected",
                   out_idx, out_last, out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_last !== e.last || out_data !== e.data) begin
            n_bad++;
            $display("FAIL fire: got idx %0d last %0b data %0h expected idx %0d last %0b data %0h",
                     out_idx, out_last, out_data, e.idx, e.last, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    out_ready = 1'b0;
    do_reset();
    tick();

    // Reset values
    chk("rst_locked",   64'(locked),    64'd0);
    chk("rst_lock_idx", 64'(lock_idx),  64'd0);
    chk("rst_credits",  64'(credits),   64'd2);
    chk("rst_proto",    64'(proto_err), 64'd0);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_ready",    64'(req_ready), 64'd0);

    // Warp 2 pair
    out_ready = 1'b1;
    set_req(2, 1, 0, 1); push(2, 0, 1); #1;
    chk("w2_first_idx", 64'(out_idx), 64'd2);
    tick();
    chk("w2_locked", 64'(locked), 64'd1);
    chk("w2_lockidx", 64'(lock_idx), 64'd2);
    chk("w2_credits", 64'(credits), 64'd1);
    set_req(2, 1, 1, 2); push(2, 1, 2); #1;
    chk("w2_second_idx", 64'(out_idx), 64'd2);
    tick();
    set_req(2, 0, 0, 0);
    chk("w2_unlocked", 64'(locked), 64'd0);
    chk("w2_credits2", 64'(credits), 64'd1);

    // rr_ptr=3: warp 3 wins over warp 0; done coincides with its first-half fire
    set_req(0, 1, 0, 3); set_req(3, 1, 0, 4); done = 1'b1; push(3, 0, 4); #1;
    chk("rr_ptr3", 64'(out_idx), 64'd3);
    tick();
    done = 1'b0;
    chk("done_fire_credits", 64'(credits), 64'd1);
    chk("w3_lockidx", 64'(lock_idx), 64'd3);
    set_req(3, 1, 1, 5); push(3, 1, 5);
    tick();
    set_req(3, 0, 0, 0);
    chk("w3_unlocked", 64'(locked), 64'd0);
    push(0, 0, 3);
    tick();
    chk("w0_credits", 64'(credits), 64'd0);
    chk("w0_lockidx", 64'(lock_idx), 64'd0);
    chk("w0_locked", 64'(locked), 64'd1);
    set_req(0, 1, 1, 6); push(0, 1, 6);
    tick();
    set_req(0, 0, 0, 0);
    chk("w0_unlocked", 64'(locked), 64'd0);

    // Credit exhaustion: warp 1 first half stalls until done
    set_req(1, 1, 0, 7); #1;
    chk("stall_valid", 64'(out_valid), 64'd0);
    chk("stall_ready", 64'(req_ready), 64'd0);
    tick();
    chk("stall_valid2", 64'(out_valid), 64'd0);
    chk("stall_credits", 64'(credits), 64'd0);
    done = 1'b1; push(1, 0, 7);
    tick();
    done = 1'b0;
    chk("done_credits", 64'(credits), 64'd1);
    chk("done_grant_valid", 64'(out_valid), 64'd1);
    chk("done_grant_idx", 64'(out_idx), 64'd1);
    tick();
    chk("w1_credits", 64'(credits), 64'd0);
    chk("w1_lockidx", 64'(lock_idx), 64'd1);

    // out_ready low during an open pair
    set_req(1, 1, 1, 8); push(1, 1, 8); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_data", out_data, dat(1, 1, 8));
      chk("hold_idx",  64'(out_idx), 64'd1);
      chk("hold_ready", 64'(req_ready), 64'd0);
      tick();
      chk("hold_locked", 64'(locked), 64'd1);
      chk("hold_credits", 64'(credits), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    set_req(1, 0, 0, 0);
    chk("hold_release", 64'(locked), 64'd0);

    // All four warps hold first halves: order 0,1,2,3,0
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) set_req(j, 1, 0, 10 + j);
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % N;
      push(w, 0, 10 + k); #1;
      chk("rr_order", 64'(out_idx), 64'(w));
      tick();
      chk("rr_lockidx", 64'(lock_idx), 64'(w));
      set_req(w, 1, 1, 20 + k); push(w, 1, 20 + k); done = 1'b1;
      tick();
      done = 1'b0;
      set_req(w, 1, 0, 14 + k);
      chk("rr_unlocked", 64'(locked), 64'd0);
    end
    clear_all();
    chk("rr_credits", 64'(credits), 64'd2);
    chk("rr_proto", 64'(proto_err), 64'd0);

    // Warp 0 locked, second half absent for 5 cycles while warp 1 waits
    set_req(0, 1, 0, 30); push(0, 0, 30);
    tick();
    set_req(0, 0, 0, 0); set_req(1, 1, 0, 31);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("gap_valid", 64'(out_valid), 64'd0);
      tick();
    end
    set_req(0, 1, 1, 32); push(0, 1, 32); push(1, 0, 31);
    tick();
    set_req(0, 0, 0, 0); #1;
    chk("gap_next_idx", 64'(out_idx), 64'd1);
    tick();
    chk("gap_lockidx", 64'(lock_idx), 64'd1);
    set_req(1, 1, 1, 33); push(1, 1, 33);
    tick();
    clear_all();

    // Protocol errors
    chk("proto_clean", 64'(proto_err), 64'd0);
    set_req(2, 1, 1, 40);
    tick();
    clear_all();
    chk("proto_nonowner", 64'(proto_err), 64'd1);
    do_reset();
    #1;
    chk("proto_rst1", 64'(proto_err), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("proto_overflow", 64'(proto_err), 64'd1);
    chk("overflow_credits", 64'(credits), 64'd2);
    do_reset();
    #1;
    chk("proto_rst2", 64'(proto_err), 64'd0);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
